// File: rtl/mealy_0110_pkg.sv
// Shared state encoding for the overlapping 0110 Mealy detector.
// Benches import this to name states when probing the detector's cs register.
package mealy_0110_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

endpackage

// File: rtl/mealy_0110_detector.sv
// Serial 0110 detector with overlap. q is a Mealy output: it rises in the same
// cycle as the final 0, and the match is consumed at the next rising edge.
module mealy_0110_detector
    import mealy_0110_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic q
);

    state_t cs;
    state_t ns;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cs <= S0;
        end else begin
            cs <= ns;
        end
    end

    // Any trailing 0 is kept as a fresh prefix, so a 0 always lands in S1.
    always_comb begin
        ns = S0;
        case (cs)
            S0:      ns = in ? S0 : S1;
            S1:      ns = in ? S2 : S1;
            S2:      ns = in ? S3 : S1;
            S3:      ns = in ? S0 : S1;
            default: ns = S0;
        endcase
    end

    always_comb begin
        q = 1'b0;
        case (cs)
            S3:      q = reset && !in;
            default: q = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mealy_0110_detector.sv
// Self-checking bench for mealy_0110_detector: directed sequences plus random bits,
// compared against a model that looks only at the recent input history.
module tb_mealy_0110_detector;
    import mealy_0110_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic q;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic sampled_q;
    bit hist[$];

    always #5 clk = ~clk;

    mealy_0110_detector dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .q     (q)
    );

    // Model state: the longest suffix of the bits seen since reset that is a prefix of 0110.
    function automatic state_t modelState();
        int n = hist.size();
        if (n >= 3 && hist[n-3] == 1'b0 && hist[n-2] == 1'b1 && hist[n-1] == 1'b1) return S3;
        if (n >= 2 && hist[n-2] == 1'b0 && hist[n-1] == 1'b1) return S2;
        if (n >= 1 && hist[n-1] == 1'b0) return S1;
        return S0;
    endfunction

    function automatic logic modelQ(input logic r, input logic b);
        int n = hist.size();
        if (!r) return 1'b0;
        return (n >= 3 && hist[n-3] == 1'b0 && hist[n-2] == 1'b1 && hist[n-1] == 1'b1 && b == 1'b0);
    endfunction

    task automatic modelEdge(input logic r, input logic b);
        if (!r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    // One clock: drive at the falling edge, check q before the rising edge, check cs after it.
    task automatic applyStimulus(input string tag, input logic r, input logic b);
        @(negedge clk);
        reset = r;
        in    = b;
        #1;
        sampled_q = q;
        checkOutput({tag, "_q"}, {1'b0, q}, {1'b0, modelQ(r, b)});
        @(posedge clk);
        #1;
        modelEdge(r, b);
        checkOutput({tag, "_cs"}, dut.cs, modelState());
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish in time");
    end

    initial begin
        logic [2:0] basic_head  = 3'b011;
        logic [6:0] ovl_bits    = 7'b0110110;
        logic [6:0] ovl_q       = 7'b0001001;
        logic [9:0] near_bits   = 10'b0111010010;
        logic [2:0] mid_bits    = 3'b011;

        reset = 1'b0;
        in    = 1'b1;

        applyStimulus("rst_a", 1'b0, 1'b1);
        checkOutput("rst_a_q0", {1'b0, sampled_q}, 2'b00);
        applyStimulus("rst_b", 1'b0, 1'b1);
        checkOutput("rst_b_q0", {1'b0, sampled_q}, 2'b00);
        checkOutput("rst_cs_s0", dut.cs, S0);

        for (int i = 2; i >= 0; i--) begin
            applyStimulus("basic", 1'b1, basic_head[i]);
            checkOutput("basic_noq", {1'b0, sampled_q}, 2'b00);
        end
        checkOutput("basic_cs_s3", dut.cs, S3);

        // Fourth bit: wiggle in between edges, q must follow immediately while cs holds.
        @(negedge clk);
        in = 1'b1;
        #1;
        checkOutput("mid_in1_q", {1'b0, q}, 2'b00);
        #1;
        in = 1'b0;
        #1;
        checkOutput("mid_in0_q", {1'b0, q}, 2'b01);
        checkOutput("mid_cs_hold", dut.cs, S3);
        @(posedge clk);
        #1;
        modelEdge(1'b1, 1'b0);
        checkOutput("basic_cs_after", dut.cs, S1);
        checkOutput("basic_q_consumed", {1'b0, q}, 2'b00);

        applyStimulus("ovl_rst", 1'b0, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            applyStimulus("ovl", 1'b1, ovl_bits[i]);
            checkOutput("ovl_hit", {1'b0, sampled_q}, {1'b0, ovl_q[i]});
        end

        applyStimulus("near_rst", 1'b0, 1'b0);
        for (int i = 9; i >= 0; i--) begin
            applyStimulus("near", 1'b1, near_bits[i]);
            checkOutput("near_noq", {1'b0, sampled_q}, 2'b00);
            if (i == 6) checkOutput("near_cs_bit4", dut.cs, S0);
        end

        applyStimulus("midrst_rst", 1'b0, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            applyStimulus("midrst", 1'b1, mid_bits[i]);
        end
        applyStimulus("midrst_pulse", 1'b0, 1'b1);
        checkOutput("midrst_pulse_cs", dut.cs, S0);
        applyStimulus("midrst_after", 1'b1, 1'b0);
        checkOutput("midrst_after_q", {1'b0, sampled_q}, 2'b00);
        checkOutput("midrst_after_cs", dut.cs, S1);

        applyStimulus("rand_rst", 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            applyStimulus("rand", 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mealy_0110_detector.md
MEALY_0110_DETECTOR -- requirements
Module: mealy_0110

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous active-low reset; 0 at a rising clk edge resets the block.
REQ-004 in  input  1  serial data bit, sampled on each rising clk edge.
REQ-005 q  output  1  Mealy detect flag; 1 while the current in completes the sequence 0110.
REQ-006 The block SHALL hold its current state in an internal 2-bit register named cs, readable hierarchically by benches.

Function
REQ-007 The block SHALL detect the serial pattern 0,1,1,0 (first bit oldest) with overlapping allowed.
REQ-008 States and encodings (cs) SHALL be:
- S0 = 2'b00: idle, no useful prefix.
- S1 = 2'b01: "0" seen.
- S2 = 2'b10: "01" seen.
- S3 = 2'b11: "011" seen.
REQ-009 Transitions on a rising clk edge with reset=1 SHALL be:
- S0: in=0 -> S1; in=1 -> S0.
- S1: in=0 -> S1; in=1 -> S2.
- S2: in=0 -> S1; in=1 -> S3.
- S3: in=0 -> S1 (overlap: final 0 is a new prefix); in=1 -> S0.
REQ-010 q SHALL be combinational (Mealy): q = 1 exactly when reset=1, cs=S3 and in=0; otherwise q = 0.
REQ-011 q SHALL respond to in in the same cycle with zero clock latency; the detection is consumed at the next rising edge.
REQ-012 Back-to-back overlapping matches (e.g. 0110110) SHALL each assert q; a trailing 0 SHALL never be lost.
REQ-013 in changes between clock edges SHALL affect q immediately but cs only at the next rising edge.
REQ-014 Unreachable or unknown encodings cannot occur with 2 bits; the default branch SHALL go to S0 with q = 0.

Reset
REQ-015 When reset = 0 at a rising clk edge, cs SHALL become S0 regardless of in.
REQ-016 While reset = 0, q SHALL be 0.
REQ-017 Reset asserted mid-sequence (any state) SHALL discard the partial match; detection restarts from S0 after release.
REQ-018 There SHALL be no asynchronous reset path; the first edge after power-up with reset = 0 defines the state.

Structure
REQ-019 The state encodings S0..S3 SHALL be defined once in a shared package (e.g. mealy_0110_pkg) as a 2-bit enumerated state type, for reuse by benches.
REQ-020 The design SHALL be a single module with a registered state process, a combinational next-state process and a combinational output process; no sub-module is needed.

Verification
REQ-021 Reset: hold reset=0 for 2 edges with in=1 -> cs=S0 and q=0 throughout.
REQ-022 Basic match: after reset, in=0,1,1,0 on consecutive edges -> q=1 only during the 4th bit (cs=S3, in=0); cs=S1 afterwards.
REQ-023 Overlap: in=0,1,1,0,1,1,0 -> q=1 during bits 4 and 7 only.
REQ-024 Near misses: in=0,1,1,1,0,1,0,0,1,0 -> q never 1; cs=S0 after the 4th bit.
REQ-025 Mid-sequence reset: in=0,1,1, then reset=0 for one edge, then in=0 -> q=0 and cs=S1.
REQ-026 Random: 50 random bits -> q matches a reference model of REQ-009/REQ-010 every cycle.
